mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-beat memory port between an I-cache refill engine
// (4-beat, 16-byte line bursts) and a data port (single word load/store).
// An IDLE cycle samples both requests; the winner's transaction starts on
// the next edge. There is always at least one IDLE cycle between transactions.
// Address, write data and write strobe of the winner are captured at grant,
// so the requester may change them once the transaction is under way.
//
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : on a conflict the data port always wins (fixed priority).
//   defined   : on a conflict the requester that was not granted last wins.
//               The last-granted pointer is updated on every grant and
//               resets to "I granted last".
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   i_req         in   refill request, held until i_done
//   i_addr[31:0]  in   refill address, [3:0] ignored
//   i_rvalid      out  refill beat valid (= mem_ack during the burst)
//   i_rdata[31:0] out  refill beat data
//   i_beat[1:0]   out  index of the beat in progress
//   i_done        out  pulse with the final beat's ack
//   d_req         in   data request, held until d_done
//   d_we          in   write strobe
//   d_addr[31:0]  in   word address, [1:0] ignored
//   d_wdata[31:0] in   store data
//   d_done        out  completion pulse
//   d_rdata[31:0] out  load data, valid with d_done
//   mem_req       out  beat request, held until mem_ack
//   mem_we        out  beat is a write
//   mem_addr[31:0]  out  beat byte address
//   mem_wdata[31:0] out  beat write data
//   mem_ack       in   beat completes this cycle
//   mem_rdata[31:0] in   read data, valid with mem_ack on reads
//   conflict_cnt[15:0] out  saturating count of IDLE cycles with both requests
// ---------------------------------------------------------------------------
module mem_port_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic [1:0]  i_beat,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [15:0] conflict_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      I_BURST  = 2'd1,
      D_ACCESS = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  beat_q, beat_d;
   logic [27:0] line_q, line_d;     // refill line address, i_addr[31:4]
   logic [29:0] waddr_q, waddr_d;   // data word address, d_addr[31:2]
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] cnt_q, cnt_d;

   logic        conflict;
   logic        grant_i;
   logic        grant_d;

`ifdef MEM_ARB_RR_EN
   logic        last_i_q, last_i_d; // 1: the I port was granted most recently
`endif

   // Line-offset and byte-offset bits never reach the memory port.
   logic unused_bits;
   assign unused_bits = ^{i_addr[3:0], d_addr[1:0]};

   assign conflict     = i_req & d_req;
   assign conflict_cnt = cnt_q;
   assign i_beat       = beat_q;

   // -----------------------------------------------------------------------
   // Next-state and output logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      line_d    = line_q;
      waddr_d   = waddr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_i_d  = last_i_q;
`endif
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      i_rvalid  = 1'b0;
      i_rdata   = 32'h0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      d_rdata   = 32'h0;

      case (state_q)
         IDLE: begin
            if (conflict && (cnt_q != 16'hFFFF)) begin
               cnt_d = cnt_q + 16'd1;
            end

`ifdef MEM_ARB_RR_EN
            if (conflict) begin
               grant_d = last_i_q;
               grant_i = ~last_i_q;
            end else begin
               grant_d = d_req;
               grant_i = i_req;
            end
`else
            grant_d = d_req;
            grant_i = i_req & ~d_req;
`endif

            if (grant_d) begin
               state_d = D_ACCESS;
               waddr_d = d_addr[31:2];
               we_d    = d_we;
               wdata_d = d_wdata;
            end else if (grant_i) begin
               state_d = I_BURST;
               line_d  = i_addr[31:4];
               beat_d  = 2'd0;
            end

`ifdef MEM_ARB_RR_EN
            if (grant_d) begin
               last_i_d = 1'b0;
            end else if (grant_i) begin
               last_i_d = 1'b1;
            end
`endif
         end

         I_BURST: begin
            mem_req  = 1'b1;
            mem_addr = {line_q, beat_q, 2'b00};
            i_rvalid = mem_ack;
            i_rdata  = mem_rdata;
            if (mem_ack) begin
               // Beat 3 + 1 wraps to 0, leaving the counter ready for the next burst.
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  i_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         D_ACCESS: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {waddr_q, 2'b00};
            mem_wdata = wdata_q;
            d_rdata   = mem_rdata;
            if (mem_ack) begin
               d_done  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         beat_q   <= 2'd0;
         line_q   <= 28'h0;
         waddr_q  <= 30'h0;
         we_q     <= 1'b0;
         wdata_q  <= 32'h0;
         cnt_q    <= 16'h0;
`ifdef MEM_ARB_RR_EN
         last_i_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         line_q   <= line_d;
         waddr_q  <= waddr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
`ifdef MEM_ARB_RR_EN
         last_i_q <= last_i_d;
`endif
      end
   end

endmodule
